// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, ALU operation codes and carried control bundle
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    localparam logic [2:0] ALU_ADDU = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_SUBU = 3'b100;
    localparam logic [2:0] ALU_SUB  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              mem_read;
    } ctl_t;

endpackage

// File: rtl/alu_operand_stage_if.sv
// rtl/alu_operand_stage_if.sv - decode-side instruction handshake into the operand stage
interface alu_operand_stage_if;
    import alu_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [REG_AW-1:0] in_rs;
    logic [REG_AW-1:0] in_rt;
    logic [REG_AW-1:0] in_rd;
    logic [DATA_W-1:0] in_rs_data;
    logic [DATA_W-1:0] in_rt_data;
    logic [DATA_W-1:0] in_imm;
    logic              in_use_imm;
    logic [2:0]        in_aluctr;
    logic              in_reg_write;
    logic              in_mem_read;

    modport master (
        output in_valid, in_rs, in_rt, in_rd, in_rs_data, in_rt_data,
               in_imm, in_use_imm, in_aluctr, in_reg_write, in_mem_read,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_rs, in_rt, in_rd, in_rs_data, in_rt_data,
               in_imm, in_use_imm, in_aluctr, in_reg_write, in_mem_read,
        output in_ready
    );

endinterface

// File: rtl/operand_fwd_sel.sv
// rtl/operand_fwd_sel.sv - EX/MEM hit detection and forwarding mux for one source register
module operand_fwd_sel
    import alu_pkg::*;
#(
    parameter bit FWD_EN = 1'b1
) (
    input  logic [REG_AW-1:0] src,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              ex_wr,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              ex_hit,
    output logic              mem_hit,
    output logic [DATA_W-1:0] fwd_data
);

    logic src_nz;

    // r0 is hardwired zero, so a producer targeting it never matches
    assign src_nz  = (src != '0);
    assign ex_hit  = ex_wr && (ex_rd == src) && src_nz;
    assign mem_hit = mem_reg_write && (mem_rd == src) && src_nz;

    assign fwd_data = (FWD_EN && ex_hit)  ? ex_result :
                      (FWD_EN && mem_hit) ? mem_wdata :
                                            rf_data;

endmodule

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - ID/EX operand stage with forwarding and load-use stall (ALU_OPERAND_FWD_EN)
module alu_operand_stage
    import alu_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    alu_operand_stage_if.slave      dec,
    input  logic [DATA_W-1:0]       ex_result,
    input  logic [REG_AW-1:0]       mem_rd,
    input  logic                    mem_reg_write,
    input  logic [DATA_W-1:0]       mem_wdata,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       X,
    output logic [DATA_W-1:0]       Y,
    output logic [2:0]              ALUctr,
    output logic [REG_AW-1:0]       out_rd,
    output logic                    out_reg_write,
    output logic                    out_mem_read
);

`ifdef ALU_OPERAND_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    ctl_t              ctl_q;
    ctl_t              ctl_d;
    logic              ex_wr;
    logic              rt_used;
    logic              advance;
    logic              accept;
    logic              hazard;
    logic              rs_ex_hit, rs_mem_hit, rt_ex_hit, rt_mem_hit;
    logic [DATA_W-1:0] rs_fwd, rt_fwd;

    assign ex_wr   = out_valid && out_reg_write;
    assign rt_used = !dec.in_use_imm;

    operand_fwd_sel #(.FWD_EN(FWD_EN)) u_rs_sel (
        .src           (dec.in_rs),
        .rf_data       (dec.in_rs_data),
        .ex_wr         (ex_wr),
        .ex_rd         (out_rd),
        .ex_result     (ex_result),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .mem_wdata     (mem_wdata),
        .ex_hit        (rs_ex_hit),
        .mem_hit       (rs_mem_hit),
        .fwd_data      (rs_fwd)
    );

    operand_fwd_sel #(.FWD_EN(FWD_EN)) u_rt_sel (
        .src           (dec.in_rt),
        .rf_data       (dec.in_rt_data),
        .ex_wr         (ex_wr),
        .ex_rd         (out_rd),
        .ex_result     (ex_result),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .mem_wdata     (mem_wdata),
        .ex_hit        (rt_ex_hit),
        .mem_hit       (rt_mem_hit),
        .fwd_data      (rt_fwd)
    );

    // With forwarding only a load in EX is unresolvable; without it any in-flight producer stalls
    assign hazard = FWD_EN ? (out_mem_read && (rs_ex_hit || (rt_used && rt_ex_hit)))
                           : (rs_ex_hit || rs_mem_hit || (rt_used && (rt_ex_hit || rt_mem_hit)));

    assign advance      = !out_valid || out_ready;
    assign dec.in_ready = advance && !hazard;
    assign accept       = dec.in_valid && dec.in_ready;

    assign ctl_d.rd        = dec.in_rd;
    assign ctl_d.reg_write = dec.in_reg_write;
    assign ctl_d.mem_read  = dec.in_mem_read;

    assign out_rd        = ctl_q.rd;
    assign out_reg_write = ctl_q.reg_write;
    assign out_mem_read  = ctl_q.mem_read;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            X         <= '0;
            Y         <= '0;
            ALUctr    <= 3'b000;
            ctl_q     <= '0;
        end else if (flush) begin
            // an instruction accepted alongside flush is consumed and dropped
            out_valid <= 1'b0;
        end else if (advance) begin
            out_valid <= accept;
            if (accept) begin
                X      <= rs_fwd;
                Y      <= dec.in_use_imm ? dec.in_imm : rt_fwd;
                ALUctr <= dec.in_aluctr;
                ctl_q  <= ctl_d;
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - directed self-checking bench for alu_operand_stage
module tb_alu_operand_stage;
    import alu_pkg::*;

    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] ex_result;
    logic [REG_AW-1:0] mem_rd;
    logic              mem_reg_write;
    logic [DATA_W-1:0] mem_wdata;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] X;
    logic [DATA_W-1:0] Y;
    logic [2:0]        ALUctr;
    logic [REG_AW-1:0] out_rd;
    logic              out_reg_write;
    logic              out_mem_read;

    int checks;
    int errors;

    alu_operand_stage_if dec ();

    alu_operand_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .dec           (dec),
        .ex_result     (ex_result),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .mem_wdata     (mem_wdata),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .X             (X),
        .Y             (Y),
        .ALUctr        (ALUctr),
        .out_rd        (out_rd),
        .out_reg_write (out_reg_write),
        .out_mem_read  (out_mem_read)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                         input logic use_imm, input logic [2:0] ctl, input logic rw, input logic mr);
        dec.in_valid     = v;
        dec.in_rs        = rs;
        dec.in_rt        = rt;
        dec.in_rd        = rd;
        dec.in_rs_data   = rsd;
        dec.in_rt_data   = rtd;
        dec.in_imm       = imm;
        dec.in_use_imm   = use_imm;
        dec.in_aluctr    = ctl;
        dec.in_reg_write = rw;
        dec.in_mem_read  = mr;
        #1;
    endtask

    task automatic idle();
        dec.in_valid  = 1'b0;
        mem_reg_write = 1'b0;
        flush         = 1'b0;
        out_ready     = 1'b1;
        step();
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 3'b000, 1'b0, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (X !== 32'h0 || Y !== 32'h0) begin errors++; $display("FAIL reset_xy: got X=%h Y=%h want 0", X, Y); end
        checks++; if (ALUctr !== 3'b000 || out_rd !== 5'd0 || out_reg_write !== 1'b0 || out_mem_read !== 1'b0) begin
            errors++; $display("FAIL reset_ctl: got ctr=%b rd=%0d rw=%b mr=%b want 0", ALUctr, out_rd, out_reg_write, out_mem_read); end
        checks++; if (dec.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", dec.in_ready); end
    endtask

    task automatic test_basic();
        drive(1'b1, 5'd1, 5'd2, 5'd4, 32'h80000000, 32'hf0000000, 32'h0, 1'b0, ALU_ADD, 1'b1, 1'b0);
        step();
        dec.in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", out_valid); end
        checks++; if (X !== 32'h80000000) begin errors++; $display("FAIL basic_x: got %h want 80000000", X); end
        checks++; if (Y !== 32'hf0000000) begin errors++; $display("FAIL basic_y: got %h want f0000000", Y); end
        checks++; if (ALUctr !== 3'b001 || out_rd !== 5'd4 || out_reg_write !== 1'b1) begin
            errors++; $display("FAIL basic_ctl: got ctr=%b rd=%0d rw=%b want 001/4/1", ALUctr, out_rd, out_reg_write); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h0, 1'b0, ALU_ADDU, 1'b1, 1'b0);
        step();
        ex_result = 32'h70000000;
        drive(1'b1, 5'd3, 5'd0, 5'd3, 32'h11111111, 32'h0, 32'h0, 1'b0, ALU_OR, 1'b1, 1'b0);
        checks++; if (dec.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", dec.in_ready); end
        step();
        checks++; if (X !== 32'h70000000) begin errors++; $display("FAIL b2b_x_fwd: got %h want 70000000", X); end
        // EX result must win over a MEM producer of the same register
        ex_result = 32'hbbbbbbbb; mem_rd = 5'd3; mem_reg_write = 1'b1; mem_wdata = 32'haaaaaaaa;
        drive(1'b1, 5'd3, 5'd3, 5'd8, 32'h0, 32'h0, 32'h00001234, 1'b1, ALU_SUB, 1'b1, 1'b0);
        step();
        dec.in_valid = 1'b0; mem_reg_write = 1'b0;
        checks++; if (X !== 32'hbbbbbbbb) begin errors++; $display("FAIL b2b_ex_priority: got %h want bbbbbbbb", X); end
        checks++; if (Y !== 32'h00001234) begin errors++; $display("FAIL b2b_imm: got %h want 00001234", Y); end
        idle();
    endtask

    task automatic test_load_use();
        drive(1'b1, 5'd1, 5'd0, 5'd5, 32'h0, 32'h0, 32'h4, 1'b1, ALU_ADDU, 1'b1, 1'b1);
        step();
        ex_result = 32'hdeadbeef;
        drive(1'b1, 5'd1, 5'd5, 5'd6, 32'h5, 32'h99, 32'h0, 1'b0, ALU_SUBU, 1'b1, 1'b0);
        checks++; if (dec.in_ready !== 1'b0) begin errors++; $display("FAIL lu_stall: got in_ready=%b want 0", dec.in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble: got out_valid=%b want 0", out_valid); end
        mem_rd = 5'd5; mem_reg_write = 1'b1; mem_wdata = 32'h10000000;
        #1;
        checks++; if (dec.in_ready !== 1'b1) begin errors++; $display("FAIL lu_release: got in_ready=%b want 1", dec.in_ready); end
        step();
        dec.in_valid = 1'b0; mem_reg_write = 1'b0;
        checks++; if (Y !== 32'h10000000 || X !== 32'h5 || out_valid !== 1'b1) begin
            errors++; $display("FAIL lu_mem_fwd: got X=%h Y=%h v=%b want 5/10000000/1", X, Y, out_valid); end
        idle();
    endtask

    task automatic test_ex_dependency();
        drive(1'b1, 5'd1, 5'd2, 5'd7, 32'h1, 32'h2, 32'h0, 1'b0, ALU_ADD, 1'b1, 1'b0);
        step();
        ex_result = 32'h0000abcd;
        drive(1'b1, 5'd7, 5'd0, 5'd9, 32'h00000777, 32'h0, 32'h0, 1'b0, ALU_OR, 1'b1, 1'b0);
`ifdef ALU_OPERAND_FWD_EN
        checks++; if (dec.in_ready !== 1'b1) begin errors++; $display("FAIL dep_no_stall: got in_ready=%b want 1", dec.in_ready); end
        step();
        checks++; if (X !== 32'h0000abcd) begin errors++; $display("FAIL dep_fwd_x: got %h want 0000abcd", X); end
`else
        checks++; if (dec.in_ready !== 1'b0) begin errors++; $display("FAIL dep_ex_stall: got in_ready=%b want 0", dec.in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dep_bubble1: got %b want 0", out_valid); end
        mem_rd = 5'd7; mem_reg_write = 1'b1; mem_wdata = 32'h0000abcd;
        #1;
        checks++; if (dec.in_ready !== 1'b0) begin errors++; $display("FAIL dep_mem_stall: got in_ready=%b want 0", dec.in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dep_bubble2: got %b want 0", out_valid); end
        mem_reg_write = 1'b0;
        #1;
        checks++; if (dec.in_ready !== 1'b1) begin errors++; $display("FAIL dep_release: got in_ready=%b want 1", dec.in_ready); end
        step();
        checks++; if (X !== 32'h00000777 || out_valid !== 1'b1) begin
            errors++; $display("FAIL dep_rf_x: got X=%h v=%b want 00000777/1", X, out_valid); end
`endif
        dec.in_valid = 1'b0;
        idle();
    endtask

    task automatic test_r0();
        drive(1'b1, 5'd1, 5'd2, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, ALU_ADDU, 1'b1, 1'b1);
        step();
        ex_result = 32'hdeadbeef; mem_rd = 5'd0; mem_reg_write = 1'b1; mem_wdata = 32'hcafef00d;
        drive(1'b1, 5'd0, 5'd0, 5'd2, 32'h0, 32'h33, 32'h0, 1'b0, ALU_SLT, 1'b1, 1'b0);
        checks++; if (dec.in_ready !== 1'b1) begin errors++; $display("FAIL r0_no_stall: got in_ready=%b want 1", dec.in_ready); end
        step();
        dec.in_valid = 1'b0; mem_reg_write = 1'b0;
        checks++; if (X !== 32'h0 || Y !== 32'h33 || ALUctr !== 3'b111) begin
            errors++; $display("FAIL r0_no_fwd: got X=%h Y=%h ctr=%b want 0/33/111", X, Y, ALUctr); end
    endtask

    task automatic test_stall_flush();
        out_ready = 1'b0;
        drive(1'b1, 5'd9, 5'd10, 5'd11, 32'h5555, 32'h6666, 32'h0, 1'b0, ALU_SUB, 1'b1, 1'b0);
        checks++; if (dec.in_ready !== 1'b0) begin errors++; $display("FAIL hold_ready1: got %b want 0", dec.in_ready); end
        step();
        checks++; if (out_valid !== 1'b1 || X !== 32'h0 || Y !== 32'h33 || ALUctr !== 3'b111 || out_rd !== 5'd2) begin
            errors++; $display("FAIL hold_stable: got v=%b X=%h Y=%h ctr=%b rd=%0d want 1/0/33/111/2", out_valid, X, Y, ALUctr, out_rd); end
        flush = 1'b1;
        #1;
        checks++; if (dec.in_ready !== 1'b0) begin errors++; $display("FAIL hold_ready2: got %b want 0", dec.in_ready); end
        step();
        flush = 1'b0; dec.in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || Y !== 32'h33) begin
            errors++; $display("FAIL hold_flush: got v=%b Y=%h want 0/33", out_valid, Y); end
        checks++; if (dec.in_ready !== 1'b1) begin errors++; $display("FAIL hold_empty_ready: got %b want 1", dec.in_ready); end
        step();
        out_ready = 1'b1;
    endtask

    task automatic test_flush_accept();
        drive(1'b1, 5'd12, 5'd13, 5'd14, 32'h12121212, 32'h13131313, 32'h0, 1'b0, ALU_OR, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        checks++; if (dec.in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", dec.in_ready); end
        step();
        flush = 1'b0; dec.in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || X !== 32'h0) begin
            errors++; $display("FAIL flush_drop: got v=%b X=%h want 0/0", out_valid, X); end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 5'd1, 5'd2, 5'd15, 32'h01020304, 32'h05060708, 32'h0, 1'b0, ALU_SLTU, 1'b1, 1'b1);
        step();
        dec.in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || X !== 32'h01020304) begin
            errors++; $display("FAIL mid_load: got v=%b X=%h want 1/01020304", out_valid, X); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++; if (out_valid !== 1'b0 || X !== 32'h0 || Y !== 32'h0 || ALUctr !== 3'b000 ||
                      out_rd !== 5'd0 || out_reg_write !== 1'b0 || out_mem_read !== 1'b0) begin
            errors++; $display("FAIL mid_reset: got v=%b X=%h Y=%h ctr=%b rd=%0d rw=%b mr=%b want all 0",
                               out_valid, X, Y, ALUctr, out_rd, out_reg_write, out_mem_read); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        ex_result = '0; mem_rd = '0; mem_reg_write = 1'b0; mem_wdata = '0;
        flush = 1'b0; out_ready = 1'b1;
        test_reset();
        test_basic();
`ifdef ALU_OPERAND_FWD_EN
        test_back_to_back();
        test_load_use();
`endif
        test_ex_dependency();
        test_r0();
        test_stall_flush();
        test_flush_accept();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
